// File: rtl/ram_8x4_bist.sv
// ram_8x4_bist: built-in self-test controller for the 8x4 RAM.
//
// Sits upstream of the RAM and owns its en/addr/data_in port. A start pulse
// writes pattern A (a+1) to every location, then reads it back and compares
// each word. It then repeats the write and read with pattern B (~(a+1)).
// While idle, the RAM port is held quiet with en=0.
//
// Ports:
//   clk       - rising-edge clock, shared with the RAM
//   rst       - asynchronous active-high reset
//   start     - one-cycle run request, honoured only in IDLE or DONE
//   ram_en    - RAM en (1 = write, 0 = read)
//   ram_addr  - RAM address
//   ram_din   - RAM write data
//   ram_dout  - RAM read data, valid RD_LAT cycles after the address
//   busy      - test in progress
//   done      - test finished; holds until the next start or rst
//   pass      - valid with done, 1 when no mismatch was seen
//   fail_addr - address of the first mismatch (0 if none)
//   err_count - mismatch count, saturating at 15
module ram_8x4_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [3:0]        err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              p_q, p_d;
  logic [3:0]        err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  // Compare stage: expected word and address, aligned with ram_dout.
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic pat_b,
                                                input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = DATA_W'(addr) + DATA_W'(1);
    return pat_b ? ~v : v;
  endfunction

  generate
    if (RD_LAT == 0) begin : g_lat0
      // Asynchronous-read RAM: data belongs to the address issued this cycle.
      always_comb begin
        cmp_vld  = (state_q == S_RD);
        cmp_exp  = pattern(p_q, a_q);
        cmp_addr = a_q;
      end
    end else begin : g_lat1
      // One-deep pipeline so the expected word lines up with registered read data.
      logic              rd_vld_q, rd_vld_d;
      logic [DATA_W-1:0] rd_exp_q, rd_exp_d;
      logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

      always_comb begin
        rd_vld_d  = (state_q == S_RD);
        rd_exp_d  = pattern(p_q, a_q);
        rd_addr_d = a_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_vld_q  <= 1'b0;
          rd_exp_q  <= '0;
          rd_addr_q <= '0;
        end else begin
          rd_vld_q  <= rd_vld_d;
          rd_exp_q  <= rd_exp_d;
          rd_addr_q <= rd_addr_d;
        end
      end

      assign cmp_vld  = rd_vld_q;
      assign cmp_exp  = rd_exp_q;
      assign cmp_addr = rd_addr_q;
    end
  endgenerate

  assign mismatch = cmp_vld && (ram_dout != cmp_exp);

  // State register (all flops, including the registered outputs).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      p_q         <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      p_q         <= p_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic, address/pass sequencing and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    p_d         = p_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;

    if (mismatch) begin
      if (err_count_q != 4'd15) err_count_d = err_count_q + 4'd1;
      if (err_count_q == 4'd0)  fail_addr_d = cmp_addr;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR;
          a_d         = '0;
          p_d         = 1'b0;
          err_count_d = '0;
          fail_addr_d = '0;
        end
      end
      S_WR: begin
        if (a_q == LAST_ADDR) begin
          state_d = S_RD;
          a_d     = '0;
        end else begin
          a_d = a_q + ADDR_W'(1);
        end
      end
      S_RD: begin
        if (a_q == LAST_ADDR) begin
          a_d = '0;
          if (RD_LAT != 0) begin
            state_d = S_DRAIN;
          end else if (!p_q) begin
            state_d = S_WR;
            p_d     = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          a_d = a_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Last read of the pass is compared this cycle; then end of pass.
        a_d = '0;
        if (!p_q) begin
          state_d = S_WR;
          p_d     = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so every output is a flop.
  always_comb begin
    ram_en_d   = 1'b0;
    ram_addr_d = '0;
    ram_din_d  = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    case (state_d)
      S_WR: begin
        ram_en_d   = 1'b1;
        ram_addr_d = a_d;
        ram_din_d  = pattern(p_d, a_d);
        busy_d     = 1'b1;
      end
      S_RD: begin
        ram_addr_d = a_d;
        busy_d     = 1'b1;
      end
      S_DRAIN: busy_d = 1'b1;
      S_DONE: begin
        done_d = 1'b1;
        pass_d = (err_count_d == 4'd0);
      end
      default: ;
    endcase
  end

  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ram_8x4_bist.sv
// Testbench for ram_8x4_bist: two controllers (RD_LAT=1 and RD_LAT=0), each
// driving a behavioural RAM with injectable faults (aliased address bit 2,
// stuck-at bit). Expected results come from an array-based model of the
// whole two-pattern test.
module tb_ram_8x4_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start0;
  logic       en1, en0;
  logic [2:0] addr1, addr0, fa1, fa0;
  logic [3:0] din1, din0, dout1, dout0, ec1, ec0;
  logic       busy1, busy0, done1, done0, pass1, pass0;

  ram_8x4_bist #(.ADDR_W(3), .DATA_W(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .ram_en(en1), .ram_addr(addr1),
    .ram_din(din1), .ram_dout(dout1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_addr(fa1), .err_count(ec1)
  );

  ram_8x4_bist #(.ADDR_W(3), .DATA_W(4), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .ram_en(en0), .ram_addr(addr0),
    .ram_din(din0), .ram_dout(dout0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_addr(fa0), .err_count(ec0)
  );

  // Fault configuration shared by both RAM models.
  bit         alias_en, stuck_en, stuck_val;
  logic [2:0] stuck_addr;
  logic [1:0] stuck_bit;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [2:0] eff(input logic [2:0] a);
    return alias_en ? {1'b0, a[1:0]} : a;
  endfunction

  function automatic logic [3:0] store(input logic [2:0] ea, input logic [3:0] d);
    logic [3:0] v;
    v = d;
    if (stuck_en && ea == stuck_addr) v[stuck_bit] = stuck_val;
    return v;
  endfunction

  // Behavioural RAMs: mem1 has a registered read, mem0 an asynchronous read.
  logic [3:0] mem1 [8];
  logic [3:0] mem0 [8];

  always @(posedge clk) begin
    if (en1) mem1[eff(addr1)] <= store(eff(addr1), din1);
    dout1 <= mem1[eff(addr1)];
    if (en0) mem0[eff(addr0)] <= store(eff(addr0), din0);
  end

  always_comb dout0 = mem0[eff(addr0)];

  // Every RAM write seen on either port, as {addr, data}.
  logic [6:0] wq [$];
  always @(posedge clk) begin
    if (en1) wq.push_back({addr1, din1});
    if (en0) wq.push_back({addr0, din0});
  end

  // Pattern value from arithmetic: A = (a+1) mod 16, B = 15 - A.
  function automatic logic [3:0] patv(input int p, input int a);
    int v;
    v = (a + 1) % 16;
    if (p != 0) v = 15 - v;
    return 4'(v);
  endfunction

  // Whole-test reference: play both patterns through a faulty array.
  function automatic void model(output int ec, output int fa);
    logic [3:0] m [8];
    logic [2:0] ea;
    ec = 0;
    fa = 0;
    for (int i = 0; i < 8; i++) m[i] = 4'd0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        ea = eff(3'(a));
        m[ea] = store(ea, patv(p, a));
      end
      for (int a = 0; a < 8; a++) begin
        if (m[eff(3'(a))] != patv(p, a)) begin
          if (ec == 0) fa = a;
          if (ec < 15) ec++;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit lat0, input logic v);
    if (lat0) start0 = v;
    else      start1 = v;
  endtask

  // One full test run on the chosen controller; glitch_at > 0 pulses start
  // during that busy cycle, which must be ignored.
  task automatic run(input bit lat0, input int glitch_at, input string tag);
    int exp_ec, exp_fa, busy_n, guard;
    model(exp_ec, exp_fa);
    wq.delete();
    @(negedge clk);
    set_start(lat0, 1'b1);
    @(negedge clk);
    set_start(lat0, 1'b0);
    check({tag, "/start_busy"}, lat0 ? busy0 : busy1, 1);
    check({tag, "/start_done"}, lat0 ? done0 : done1, 0);
    check({tag, "/start_ec"},   lat0 ? ec0 : ec1, 0);
    check({tag, "/start_fa"},   lat0 ? fa0 : fa1, 0);
    check({tag, "/first_wr"},   lat0 ? {en0, addr0, din0} : {en1, addr1, din1}, {1'b1, 3'd0, 4'd1});
    busy_n = 0;
    guard  = 0;
    while (!(lat0 ? done0 : done1) && guard < 200) begin
      if (lat0 ? busy0 : busy1) busy_n++;
      set_start(lat0, (glitch_at > 0 && busy_n == glitch_at) ? 1'b1 : 1'b0);
      @(negedge clk);
      guard++;
    end
    set_start(lat0, 1'b0);
    check({tag, "/done"},   lat0 ? done0 : done1, 1);
    check({tag, "/busy_n"}, busy_n, lat0 ? 32 : 34);
    check({tag, "/busy_end"}, lat0 ? busy0 : busy1, 0);
    check({tag, "/ram_en"}, lat0 ? en0 : en1, 0);
    check({tag, "/ec"},     lat0 ? ec0 : ec1, exp_ec);
    check({tag, "/fa"},     lat0 ? fa0 : fa1, exp_fa);
    check({tag, "/pass"},   lat0 ? pass0 : pass1, (exp_ec == 0) ? 1 : 0);
    check({tag, "/n_wr"},   wq.size(), 16);
    for (int i = 0; i < 16 && i < wq.size(); i++)
      check($sformatf("%s/wr%0d", tag, i), wq[i], {3'(i % 8), patv(i / 8, i % 8)});
    $display("run %s: lat0=%0d busy=%0d ec=%0d fa=%0d pass=%0d", tag, lat0, busy_n,
             lat0 ? ec0 : ec1, lat0 ? fa0 : fa1, lat0 ? pass0 : pass1);
  endtask

  task automatic no_faults();
    alias_en = 0; stuck_en = 0; stuck_val = 0; stuck_addr = 0; stuck_bit = 0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 8; i++) begin
      mem1[i] = 4'd0;
      mem0[i] = 4'd0;
    end
    no_faults();
    rst = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;

    // 1. Reset with clock running, then idle without start.
    repeat (3) @(negedge clk);
    check("rst/outs1", {en1, addr1, din1, busy1, done1, pass1, fa1, ec1}, 0);
    check("rst/outs0", {en0, addr0, din0, busy0, done0, pass0, fa0, ec0}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle/quiet", {en1, busy1, done1, addr1, en0, busy0, done0}, 0);
    end

    // 2. Good RAM.
    run(0, 0, "good");

    // 3. Address 5 bit 0 stuck at 0.
    stuck_en = 1; stuck_addr = 3'd5; stuck_bit = 2'd0; stuck_val = 1'b0;
    run(0, 0, "stuck5");

    // 4. Address bit 2 ignored.
    no_faults();
    alias_en = 1;
    run(0, 0, "alias");

    // 5. Restart from DONE (previous errors must clear) with an ignored start.
    run(0, 10, "glitch");

    // 6. Reset during the third write.
    no_faults();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    guard = 0;
    while (!(en1 && addr1 == 3'd2) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("midrst/reach", {en1, addr1}, {1'b1, 3'd2});
    rst = 1'b1;
    #1;
    check("midrst/outs", {en1, addr1, din1, busy1, done1, pass1, fa1, ec1}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, "after_rst");
    run(1, 0, "good_lat0");

    // Randomized fault mixes on both controllers.
    for (int k = 0; k < 6; k++) begin
      alias_en   = 1'($urandom_range(0, 1));
      stuck_en   = 1'($urandom_range(0, 1));
      stuck_addr = 3'($urandom_range(0, 7));
      stuck_bit  = 2'($urandom_range(0, 3));
      stuck_val  = 1'($urandom_range(0, 1));
      run(1'($urandom_range(0, 1)), $urandom_range(0, 30), $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_8x4_bist.md
Name: ram_8x4_bist

Overview:
Built-in self-test controller that sits directly upstream of ram_8x4 and drives its en/addr/data_in ports. It also consumes the RAM's data_out. On a start pulse it writes two data patterns across all 8 locations, reads each back and compares, then reports pass/fail, the first failing address and an error count. In mission mode it is idle and holds the RAM port quiet (en=0).

Parameters:
ADDR_W, 3, RAM address width; the test covers 2**ADDR_W locations.
DATA_W, 4, RAM data width.
RD_LAT, 1, RAM read latency in cycles from address presented (en=0) to valid data_out; legal values 0 or 1.

Ports:
clk  input  1  rising-edge clock, shared with ram_8x4
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to run the test; sampled only in IDLE or DONE
ram_en  output  1  to RAM en; 1 = write, 0 = read
ram_addr  output  ADDR_W  to RAM addr
ram_din  output  DATA_W  to RAM data_in
ram_dout  input  DATA_W  from RAM data_out
busy  output  1  high while the test runs
done  output  1  level; high from test completion until the next start or rst
pass  output  1  valid while done=1; 1 when err_count==0
fail_addr  output  ADDR_W  address of the first mismatch; 0 if none
err_count  output  4  number of mismatches, saturating at 15

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ram_en=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, fail_addr=0, err_count=0. The RAM write enable drops without waiting for a clock edge.
- All outputs are registered; no combinational path from start to ram_en.
- States: IDLE, WR, RD, DRAIN, DONE. The pass index p (0 = pattern A, 1 = pattern B) is held in a register.
- Patterns, arithmetic mod 2**DATA_W: A(a) = a+1, giving 1..8. B(a) = ~(a+1), giving 14,13,...,7.
- IDLE/DONE, start=1 at an edge:
  - clear err_count, fail_addr, done and pass; p=0; a=0; go to WR.
- WR, one cycle per address:
  - ram_en=1, ram_addr=a, ram_din=pattern_p(a); the RAM writes on the same edge.
  - a increments each cycle. After a=7, go to RD with a=0.
- RD, one cycle per address:
  - ram_en=0, ram_addr=a, ram_din=0.
  - Compare ram_dout against pattern_p(a) RD_LAT cycles after the address is issued. The expected value and address are pipelined RD_LAT deep.
  - After a=7: if RD_LAT=1, go to DRAIN for one cycle to compare the last read; if RD_LAT=0, go directly to the end-of-pass decision.
- End of pass: if p=0, set p=1, a=0, go to WR. If p=1, go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0), ram_en=0.
- Mismatch handling:
  - err_count increments, saturating at 15.
  - fail_addr is captured only on the first mismatch of the run.
- busy timing: busy=1 in WR/RD/DRAIN. It covers 2*(16+RD_LAT) cycles: 34 when RD_LAT=1, 32 when RD_LAT=0. done rises on the cycle after the last busy cycle.
- start while busy is ignored; there is no restart or queueing.
- start in DONE restarts the test; done falls on the next edge.
- Address wrap: ram_addr never exceeds 7; the counter wraps to 0 at each phase change.
- rst mid-test: abort immediately; no partial results are retained.

Test Plan:
1. Assert rst with the clock running, then release -> ram_en=0, busy=0, done=0, err_count=0, ram_addr=0 throughout. No start -> the block stays IDLE with ram_en=0 indefinitely.
2. Good RAM model (RD_LAT=1), pulse start -> writes at addr 0..7 with data 1..8, reads 0..7, then writes 14,13,...,7 and reads back. busy is high for exactly 34 cycles, then done=1, pass=1, err_count=0, fail_addr=0.
3. RAM model with bit0 of addr 5 stuck at 0 -> pattern A passes (6=0110). Pattern B expects 1001 but reads 1000 -> err_count=1, fail_addr=5, pass=0.
4. RAM model ignoring addr bit2 (addr 4..7 alias 0..3) -> pattern A reads 5,6,7,8 at addr 0..3, giving 4 errors; pattern B likewise gives 4. Result: err_count=8, fail_addr=0, pass=0.
5. start pulsed on busy cycle 10 -> ignored; completion occurs at the original cycle count. start in DONE -> err_count and fail_addr cleared, done drops next cycle, full rerun.
6. rst asserted mid-WR (3rd write, addr=2) -> ram_en=0 within the same cycle, all outputs at reset values. A subsequent start begins again at pattern A, addr 0. Repeat scenario 2 with RD_LAT=0 -> busy for 32 cycles, pass=1.
